// File: rtl/wavetable_load_scheduler_pkg.sv
// Shared definitions for the wavetable load scheduler.
// Holds the voice/wavetable geometry, the scheduler state encoding and a
// helper that locates one voice's field inside a packed per-voice bus.
package wavetable_load_scheduler_pkg;

    localparam int VOICES  = 4;
    localparam int VOICE_W = 2;
    localparam int WTB_W   = 5;

    typedef enum logic {
        ARB       = 1'b0,
        WAIT_DONE = 1'b1
    } sched_state_e;

    // LSB position of voice v's wavetable number within a packed VOICES*WTB_W bus.
    function automatic int unsigned wtb_lsb(input int unsigned v);
        return v * WTB_W;
    endfunction

endpackage

// File: rtl/wavetable_load_scheduler_rr_arbiter.sv
// Round-robin arbiter for the wavetable load scheduler.
// Purely combinational: searches ptr_i+1, ptr_i+2, ... (mod VOICES) and
// grants the first pending voice.
//   pending_i    : per-voice pending mask
//   ptr_i        : index of the most recently granted voice
//   grant_vld_o  : some voice is pending
//   grant_idx_o  : index of the granted voice (0 when none)
//   grant_oh_o   : one-hot form of the grant (all zero when none)
module wavetable_load_scheduler_rr_arbiter
    import wavetable_load_scheduler_pkg::*;
(
    input  logic [VOICES-1:0]  pending_i,
    input  logic [VOICE_W-1:0] ptr_i,
    output logic               grant_vld_o,
    output logic [VOICE_W-1:0] grant_idx_o,
    output logic [VOICES-1:0]  grant_oh_o
);

    logic [VOICE_W-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        cand        = '0;
        // Visiting ptr+1 first and ptr itself last gives the rotation.
        for (int k = 1; k <= VOICES; k++) begin
            cand = VOICE_W'((int'(ptr_i) + k) % VOICES);
            if (!grant_vld_o && pending_i[cand]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = cand;
            end
        end
        grant_oh_o              = '0;
        grant_oh_o[grant_idx_o] = grant_vld_o;
    end

endmodule

// File: rtl/wavetable_load_scheduler.sv
// Wavetable load scheduler.
// Collects per-voice wavetable-change requests, issues them one at a time to
// the wavetable loader (round-robin), waits for the loader's done, and
// publishes per-voice "RAM valid" status plus the loaded wavetable number.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_stb/req_wtb_num : per-voice request strobe and requested number
//   ld_wtb_load         : single-cycle load pulse to the loader
//   ld_wtb_num/ld_voice_num : load target, stable while waiting for done
//   ld_idle/ld_done/ld_done_wtb_num : loader status and completion report
//   voice_ready         : voice RAM valid, nothing pending or in flight
//   voice_wtb_num       : last successfully loaded number per voice
//   busy                : a load is in flight or any request is pending
//   err                 : one-cycle pulse on timeout or done-number mismatch
module wavetable_load_scheduler
    import wavetable_load_scheduler_pkg::*;
#(
    parameter int TIMEOUT   = 1023,
    parameter int TIMEOUT_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [VOICES-1:0]         req_stb,
    input  logic [VOICES*WTB_W-1:0]   req_wtb_num,
    output logic                      ld_wtb_load,
    output logic [WTB_W-1:0]          ld_wtb_num,
    output logic [VOICE_W-1:0]        ld_voice_num,
    input  logic                      ld_idle,
    input  logic                      ld_done,
    input  logic [WTB_W-1:0]          ld_done_wtb_num,
    output logic [VOICES-1:0]         voice_ready,
    output logic [VOICES*WTB_W-1:0]   voice_wtb_num,
    output logic                      busy,
    output logic                      err
);

    sched_state_e         state_q, state_d;
    logic [VOICES-1:0]    pending_q, pending_d;
    logic [VOICES-1:0]    ready_q, ready_d;
    logic [WTB_W-1:0]     req_num_q [VOICES];
    logic [WTB_W-1:0]     req_num_d [VOICES];
    logic [WTB_W-1:0]     loaded_q  [VOICES];
    logic [WTB_W-1:0]     loaded_d  [VOICES];
    logic [VOICE_W-1:0]   rr_q, rr_d;
    logic                 load_q, load_d;
    logic [WTB_W-1:0]     num_q, num_d;
    logic [VOICE_W-1:0]   voice_q, voice_d;
    logic                 err_q, err_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;

    logic                 grant_vld;
    logic [VOICE_W-1:0]   grant_idx;
    logic [VOICES-1:0]    grant_oh;
    logic [VOICES-1:0]    accept;

    wavetable_load_scheduler_rr_arbiter u_arb (
        .pending_i   (pending_q),
        .ptr_i       (rr_q),
        .grant_vld_o (grant_vld),
        .grant_idx_o (grant_idx),
        .grant_oh_o  (grant_oh)
    );

    // A request for the number a ready voice already holds is redundant and
    // is dropped, so the voice keeps playing without a reload.
    always_comb begin
        accept = '0;
        for (int v = 0; v < VOICES; v++) begin
            accept[v] = req_stb[v] &&
                !(ready_q[v] &&
                  req_wtb_num[wtb_lsb(v) +: WTB_W] == loaded_q[v] &&
                  !(state_q == WAIT_DONE && voice_q == VOICE_W'(v)));
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        req_num_d = req_num_q;
        loaded_d  = loaded_q;
        rr_d      = rr_q;
        load_d    = 1'b0;
        num_d     = num_q;
        voice_d   = voice_q;
        err_d     = 1'b0;
        wd_d      = wd_q;

        unique case (state_q)
            ARB: begin
                if (ld_idle && grant_vld) begin
                    load_d    = 1'b1;
                    num_d     = req_num_q[grant_idx];
                    voice_d   = grant_idx;
                    pending_d = pending_q & ~grant_oh;
                    rr_d      = grant_idx;
                    wd_d      = '0;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_q + TIMEOUT_W'(1);
                // Completion is always booked against the latched voice_q.
                if (ld_done && ld_done_wtb_num == num_q) begin
                    loaded_d[voice_q] = num_q;
                    ready_d[voice_q]  = ~pending_q[voice_q] & ~req_stb[voice_q];
                    state_d           = ARB;
                end else if (ld_done || wd_q == TIMEOUT_W'(TIMEOUT)) begin
                    err_d              = 1'b1;
                    pending_d[voice_q] = 1'b1;
                    state_d            = ARB;
                end
            end
        endcase

        // Applied last so a new request beats a same-cycle grant clear.
        for (int v = 0; v < VOICES; v++) begin
            if (req_stb[v]) begin
                req_num_d[v] = req_wtb_num[wtb_lsb(v) +: WTB_W];
            end
            if (accept[v]) begin
                pending_d[v] = 1'b1;
                ready_d[v]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= ARB;
            pending_q <= '0;
            ready_q   <= '0;
            rr_q      <= VOICE_W'(VOICES - 1);
            load_q    <= 1'b0;
            num_q     <= '0;
            voice_q   <= '0;
            err_q     <= 1'b0;
            wd_q      <= '0;
            // NOTE: these per-voice arrays are a handful of flops, not RAM,
            // so resetting them is cheap and gives defined published values.
            for (int v = 0; v < VOICES; v++) begin
                req_num_q[v] <= '0;
                loaded_q[v]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            req_num_q <= req_num_d;
            loaded_q  <= loaded_d;
            rr_q      <= rr_d;
            load_q    <= load_d;
            num_q     <= num_d;
            voice_q   <= voice_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_wtb_out
        assign voice_wtb_num[wtb_lsb(v) +: WTB_W] = loaded_q[v];
    end

    assign ld_wtb_load  = load_q;
    assign ld_wtb_num   = num_q;
    assign ld_voice_num = voice_q;
    assign voice_ready  = ready_q;
    assign busy         = (state_q != ARB) || (|pending_q);
    assign err          = err_q;

endmodule
